// File: rtl/sparc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// sparc_ctrl_pkg : shared states, register/ALU codes and IR field constants
// Rev 1.0
// ============================================================================
package sparc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_ACC  = 4'd5,
        ST_PC_INC   = 4'd6,
        ST_BRANCH   = 4'd7,
        ST_HALT     = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_ILL = 3'd4
    } iclass_t;

    // Bus A/B codes: 0..31 address r0..r31 directly
    localparam logic [5:0] REG_R0    = 6'd0;
    localparam logic [5:0] REG_PC    = 6'd32;
    localparam logic [5:0] REG_IR    = 6'd33;
    localparam logic [5:0] REG_TEMP0 = 6'd34;

    // Bus C: r15 is only ever written through the rd selector, so 15 is free for NOLOAD
    localparam logic [5:0] C_R0      = 6'd0;
    localparam logic [5:0] C_PC      = 6'd32;
    localparam logic [5:0] C_IR      = 6'd33;
    localparam logic [5:0] C_TEMP0   = 6'd34;
    localparam logic [5:0] C_NOLOAD  = 6'h0F;
    localparam logic [3:0] C_NOCLEAR = 4'hF;

    localparam logic [3:0] ALU_ANDCC  = 4'd0;
    localparam logic [3:0] ALU_ORCC   = 4'd1;
    localparam logic [3:0] ALU_ORNCC  = 4'd2;
    localparam logic [3:0] ALU_ADDCC  = 4'd3;
    localparam logic [3:0] ALU_SRL    = 4'd4;
    localparam logic [3:0] ALU_INC4   = 4'd5;
    localparam logic [3:0] ALU_BRDISP = 4'd6;
    localparam logic [3:0] ALU_ADD    = 4'd7;
    localparam logic [3:0] ALU_NOP    = 4'hF;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;
    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [5:0] OP3_ADDCC = 6'b010000;
    localparam logic [5:0] OP3_ANDCC = 6'b010001;
    localparam logic [5:0] OP3_ORCC  = 6'b010010;
    localparam logic [5:0] OP3_ORNCC = 6'b010110;
    localparam logic [5:0] OP3_SRL   = 6'b100110;
    localparam logic [5:0] OP3_LD    = 6'b000000;
    localparam logic [5:0] OP3_ST    = 6'b000100;

    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;

    function automatic logic [5:0] rd_to_bcode(input logic [4:0] rd);
        return {1'b0, rd};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// sparc_ctrl_decode : combinational IR classification (class, ALU op, legality)
// Rev 1.0
// ============================================================================
module sparc_ctrl_decode
    import sparc_ctrl_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic [5:0] i_op3,
    input  logic [3:0] i_cond,
    output logic [2:0] o_class,
    output logic [3:0] o_alu_op,
    output logic       o_legal
);

    always_comb begin
        o_class  = CLS_ILL;
        o_alu_op = ALU_NOP;
        case (i_op)
            OP_ARITH: begin
                case (i_op3)
                    OP3_ADDCC: begin o_class = CLS_ALU; o_alu_op = ALU_ADDCC; end
                    OP3_ANDCC: begin o_class = CLS_ALU; o_alu_op = ALU_ANDCC; end
                    OP3_ORCC:  begin o_class = CLS_ALU; o_alu_op = ALU_ORCC;  end
                    OP3_ORNCC: begin o_class = CLS_ALU; o_alu_op = ALU_ORNCC; end
                    OP3_SRL:   begin o_class = CLS_ALU; o_alu_op = ALU_SRL;   end
                    default: ;
                endcase
            end
            OP_MEM: begin
                if (i_op3 == OP3_LD)
                    o_class = CLS_LD;
                else if (i_op3 == OP3_ST)
                    o_class = CLS_ST;
            end
            OP_BRANCH: begin
                // op2 occupies the upper three bits of the op3 field
                if (i_op3[5:3] == OP2_BICC &&
                    (i_cond == COND_BA  || i_cond == COND_BE || i_cond == COND_BCS ||
                     i_cond == COND_BNEG || i_cond == COND_BVS))
                    o_class = CLS_BR;
            end
            default: ;
        endcase
    end

    assign o_legal = (o_class != CLS_ILL);

endmodule
`default_nettype wire

// File: rtl/sparc_control_sequencer.sv
`default_nettype none
// ============================================================================
// sparc_control_sequencer : fetch/decode/execute control FSM with PSR
// Rev 1.0
// ============================================================================
module sparc_control_sequencer
    import sparc_ctrl_pkg::*;
#(
    parameter DATAWIDTH_BUS               = 32,
    parameter DATA_BUS_CONTROL            = 6,
    parameter DATAWIDTH_ALU_SELECTION     = 4,
    parameter DATAWIDTH_DECODER_SELECTION = 4
)(
    input  logic                                   uCONTROL_CLOCK_50,
    input  logic                                   uCONTROL_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]               uCONTROL_IR_InBUS,
    input  logic                                   uCONTROL_negative_InLow,
    input  logic                                   uCONTROL_zero_InLow,
    input  logic                                   uCONTROL_overflow_InLow,
    input  logic                                   uCONTROL_carry_InLow,
    input  logic                                   uCONTROL_setcc_InHigh,
    input  logic                                   uCONTROL_memack_InHigh,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_A_OutBUS,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_B_OutBUS,
    output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_C_OutBUS,
    output logic                                   uCONTROL_BUS_SELECTOR_A_Out,
    output logic                                   uCONTROL_BUS_SELECTOR_B_Out,
    output logic                                   uCONTROL_BUS_SELECTOR_C_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderclearselection_OutBUS,
    output logic                                   uCONTROL_busCsrc_OutHigh,
    output logic                                   uCONTROL_memrd_OutHigh,
    output logic                                   uCONTROL_memwr_OutHigh,
    output logic [3:0]                             uCONTROL_psr_OutBUS,
    output logic                                   uCONTROL_halt_OutHigh,
    output logic [3:0]                             uCONTROL_state_OutBUS
);

    state_t     r_state;
    logic [3:0] r_psr;
    logic [2:0] w_class;
    logic [3:0] w_alu_op;
    logic       w_legal;
    logic       w_taken;
    logic       w_ack;
    logic [4:0] w_rd;
    logic       w_ir_unused;

    assign w_ack       = uCONTROL_memack_InHigh;
    assign w_rd        = uCONTROL_IR_InBUS[29:25];
    assign w_ir_unused = ^uCONTROL_IR_InBUS[18:0];

    sparc_ctrl_decode u_decode (
        .i_op     (uCONTROL_IR_InBUS[31:30]),
        .i_op3    (uCONTROL_IR_InBUS[24:19]),
        .i_cond   (uCONTROL_IR_InBUS[28:25]),
        .o_class  (w_class),
        .o_alu_op (w_alu_op),
        .o_legal  (w_legal)
    );

    // PSR is {n,z,v,c}
    always_comb begin
        case (uCONTROL_IR_InBUS[28:25])
            COND_BA:   w_taken = 1'b1;
            COND_BE:   w_taken = r_psr[2];
            COND_BCS:  w_taken = r_psr[0];
            COND_BNEG: w_taken = r_psr[3];
            COND_BVS:  w_taken = r_psr[1];
            default:   w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge uCONTROL_CLOCK_50 or posedge uCONTROL_RESET_InHigh) begin
        if (uCONTROL_RESET_InHigh) begin
            r_state <= ST_RESET;
            r_psr   <= 4'b0000;
        end else begin
            case (r_state)
                ST_RESET:    r_state <= ST_FETCH;
                ST_FETCH:    if (w_ack) r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (!w_legal)
                        r_state <= ST_HALT;
                    else if (w_class == CLS_ALU)
                        r_state <= ST_EXEC;
                    else if (w_class == CLS_LD || w_class == CLS_ST)
                        r_state <= ST_MEM_ADDR;
                    else
                        r_state <= ST_BRANCH;
                end
                ST_EXEC: begin
                    if (uCONTROL_setcc_InHigh)
                        r_psr <= ~{uCONTROL_negative_InLow, uCONTROL_zero_InLow,
                                   uCONTROL_overflow_InLow, uCONTROL_carry_InLow};
                    r_state <= ST_PC_INC;
                end
                ST_MEM_ADDR: r_state <= ST_MEM_ACC;
                ST_MEM_ACC:  if (w_ack) r_state <= ST_PC_INC;
                ST_PC_INC:   r_state <= ST_FETCH;
                ST_BRANCH:   r_state <= w_taken ? ST_FETCH : ST_PC_INC;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        uCONTROL_BUS_CONTROL_A_OutBUS         = REG_R0;
        uCONTROL_BUS_CONTROL_B_OutBUS         = REG_R0;
        uCONTROL_BUS_CONTROL_C_OutBUS         = C_NOLOAD;
        uCONTROL_BUS_SELECTOR_A_Out           = 1'b0;
        uCONTROL_BUS_SELECTOR_B_Out           = 1'b0;
        uCONTROL_BUS_SELECTOR_C_Out           = 1'b0;
        uCONTROL_aluselection_OutBUS          = ALU_NOP;
        uCONTROL_decoderclearselection_OutBUS = C_NOCLEAR;
        uCONTROL_busCsrc_OutHigh              = 1'b0;
        uCONTROL_memrd_OutHigh                = 1'b0;
        uCONTROL_memwr_OutHigh                = 1'b0;
        uCONTROL_halt_OutHigh                 = 1'b0;
        case (r_state)
            ST_FETCH: begin
                uCONTROL_BUS_CONTROL_A_OutBUS = REG_PC;
                uCONTROL_memrd_OutHigh        = 1'b1;
                uCONTROL_busCsrc_OutHigh      = 1'b1;
                uCONTROL_BUS_CONTROL_C_OutBUS = w_ack ? C_IR : C_NOLOAD;
            end
            ST_EXEC: begin
                uCONTROL_BUS_SELECTOR_A_Out  = 1'b1;
                uCONTROL_BUS_SELECTOR_B_Out  = 1'b1;
                uCONTROL_BUS_SELECTOR_C_Out  = (w_rd != 5'd0);
                uCONTROL_aluselection_OutBUS = w_alu_op;
            end
            ST_MEM_ADDR: begin
                uCONTROL_BUS_SELECTOR_A_Out   = 1'b1;
                uCONTROL_BUS_SELECTOR_B_Out   = 1'b1;
                uCONTROL_aluselection_OutBUS  = ALU_ADD;
                uCONTROL_BUS_CONTROL_C_OutBUS = C_TEMP0;
            end
            ST_MEM_ACC: begin
                uCONTROL_BUS_CONTROL_A_OutBUS = REG_TEMP0;
                if (w_class == CLS_ST) begin
                    uCONTROL_memwr_OutHigh        = 1'b1;
                    uCONTROL_BUS_CONTROL_B_OutBUS = rd_to_bcode(w_rd);
                end else begin
                    uCONTROL_memrd_OutHigh      = 1'b1;
                    uCONTROL_busCsrc_OutHigh    = 1'b1;
                    uCONTROL_BUS_SELECTOR_C_Out = w_ack;
                end
            end
            ST_BRANCH: begin
                if (w_taken) begin
                    uCONTROL_BUS_CONTROL_A_OutBUS = REG_PC;
                    uCONTROL_BUS_CONTROL_B_OutBUS = REG_IR;
                    uCONTROL_aluselection_OutBUS  = ALU_BRDISP;
                    uCONTROL_BUS_CONTROL_C_OutBUS = C_PC;
                end
            end
            ST_PC_INC: begin
                uCONTROL_BUS_CONTROL_A_OutBUS = REG_PC;
                uCONTROL_aluselection_OutBUS  = ALU_INC4;
                uCONTROL_BUS_CONTROL_C_OutBUS = C_PC;
            end
            ST_HALT: uCONTROL_halt_OutHigh = 1'b1;
            default: ;
        endcase
    end

    assign uCONTROL_psr_OutBUS   = r_psr;
    assign uCONTROL_state_OutBUS = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sparc_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sparc_control_sequencer : directed scoreboard bench for the control FSM
// Rev 1.0
// ============================================================================
module tb_sparc_control_sequencer;
    import sparc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       rd, wr, cs, hl, sa, sb, sc;
        logic [5:0] ca, cb, cc;
        logic [3:0] alu, psr;
    } exp_t;

    localparam logic [5:0]  DC       = 6'h3F;
    localparam logic [31:0] I_ADDCC  = 32'h86804002;
    localparam logic [31:0] I_LD     = 32'hC6004002;
    localparam logic [31:0] I_ST     = 32'hC6204002;
    localparam logic [31:0] I_BE4    = 32'h02800004;
    localparam logic [31:0] I_ORCC0  = 32'h80904002;
    localparam logic [31:0] I_ILL    = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        n_l = 1'b1, z_l = 1'b1, v_l = 1'b1, c_l = 1'b1;
    logic        setcc = 1'b0, ack = 1'b0;
    logic [5:0]  ca, cb, cc;
    logic        sa, sb, sc, csrc, memrd, memwr, halt;
    logic [3:0]  alu, dclr, psr, st;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    sparc_control_sequencer dut (
        .uCONTROL_CLOCK_50                     (clk),
        .uCONTROL_RESET_InHigh                 (rst),
        .uCONTROL_IR_InBUS                     (ir),
        .uCONTROL_negative_InLow               (n_l),
        .uCONTROL_zero_InLow                   (z_l),
        .uCONTROL_overflow_InLow               (v_l),
        .uCONTROL_carry_InLow                  (c_l),
        .uCONTROL_setcc_InHigh                 (setcc),
        .uCONTROL_memack_InHigh                (ack),
        .uCONTROL_BUS_CONTROL_A_OutBUS         (ca),
        .uCONTROL_BUS_CONTROL_B_OutBUS         (cb),
        .uCONTROL_BUS_CONTROL_C_OutBUS         (cc),
        .uCONTROL_BUS_SELECTOR_A_Out           (sa),
        .uCONTROL_BUS_SELECTOR_B_Out           (sb),
        .uCONTROL_BUS_SELECTOR_C_Out           (sc),
        .uCONTROL_aluselection_OutBUS          (alu),
        .uCONTROL_decoderclearselection_OutBUS (dclr),
        .uCONTROL_busCsrc_OutHigh              (csrc),
        .uCONTROL_memrd_OutHigh                (memrd),
        .uCONTROL_memwr_OutHigh                (memwr),
        .uCONTROL_psr_OutBUS                   (psr),
        .uCONTROL_halt_OutHigh                 (halt),
        .uCONTROL_state_OutBUS                 (st)
    );

    function automatic exp_t E(input logic [3:0] s, input logic r, input logic w,
                               input logic c, input logic h, input logic a_s,
                               input logic b_s, input logic c_s, input logic [5:0] a_c,
                               input logic [5:0] b_c, input logic [5:0] c_c,
                               input logic [3:0] op, input logic [3:0] p);
        exp_t e;
        e.st = s; e.rd = r; e.wr = w; e.cs = c; e.hl = h;
        e.sa = a_s; e.sb = b_s; e.sc = c_s;
        e.ca = a_c; e.cb = b_c; e.cc = c_c; e.alu = op; e.psr = p;
        return e;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic cyc(input logic r, input logic [31:0] i, input logic k, input logic s,
                       input logic [3:0] fn, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst = r; ir = i; ack = k; setcc = s;
        {n_l, z_l, v_l, c_l} = fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: codes are only compared where the selector picks the code and it is not DC.
    initial begin : monitor
        exp_t  e, a;
        string nm;
        logic  bad;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.st = st; a.rd = memrd; a.wr = memwr; a.cs = csrc; a.hl = halt;
                a.sa = sa; a.sb = sb; a.sc = sc; a.ca = ca; a.cb = cb; a.cc = cc;
                a.alu = alu; a.psr = psr;
                bad = (a.st != e.st) || (a.rd != e.rd) || (a.wr != e.wr) ||
                      (a.cs != e.cs) || (a.hl != e.hl) || (a.sa != e.sa) ||
                      (a.sb != e.sb) || (a.sc != e.sc) || (a.alu != e.alu) ||
                      (a.psr != e.psr) || (dclr != C_NOCLEAR) ||
                      (!e.sa && e.ca != DC && a.ca != e.ca) ||
                      (!e.sb && e.cb != DC && a.cb != e.cb) ||
                      (!e.sc && e.cc != DC && a.cc != e.cc);
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s: actual st=%0d rd=%b wr=%b cs=%b hl=%b sel=%b%b%b A=%0d B=%0d C=%0d alu=%0d psr=%b clr=%h | required st=%0d rd=%b wr=%b cs=%b hl=%b sel=%b%b%b A=%0d B=%0d C=%0d alu=%0d psr=%b",
                             nm, a.st, a.rd, a.wr, a.cs, a.hl, a.sa, a.sb, a.sc, a.ca, a.cb, a.cc, a.alu, a.psr, dclr,
                             e.st, e.rd, e.wr, e.cs, e.hl, e.sa, e.sb, e.sc, e.ca, e.cb, e.cc, e.alu, e.psr);
                end
            end
        end
    end

    initial begin : stimulus
        // reset, then an async reset landing on a pending fetch
        cyc(1, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "rst_hold");
        cyc(0, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "rst_release");
        cyc(0, 0, 0, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_NOLOAD, ALU_NOP, 4'h0), "fetch_wait");
        cyc(1, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "rst_async_mid_fetch");
        cyc(0, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "rst_release2");
        // addcc r1,r2,r3 with zero flag; setcc during DECODE must be ignored
        cyc(0, I_ADDCC, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'h0), "addcc_fetch_ack");
        cyc(0, I_ADDCC, 0, 1, 4'h0, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "addcc_decode");
        cyc(0, I_ADDCC, 0, 1, 4'b1011, E(ST_EXEC, 0,0,0,0, 1,1,1, DC,DC,DC, ALU_ADDCC, 4'h0), "addcc_exec");
        cyc(0, I_ADDCC, 0, 0, 4'hF, E(ST_PC_INC, 0,0,0,0, 0,0,0, REG_PC,DC,C_PC, ALU_INC4, 4'b0100), "addcc_pcinc_psr");
        // ld [r1+r2],r3 with three wait states
        cyc(0, I_LD, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'b0100), "ld_fetch_ack");
        cyc(0, I_LD, 1, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0100), "ld_decode_stray_ack");
        cyc(0, I_LD, 0, 0, 4'hF, E(ST_MEM_ADDR, 0,0,0,0, 1,1,0, DC,DC,C_TEMP0, ALU_ADD, 4'b0100), "ld_mem_addr");
        for (int w = 0; w < 3; w++)
            cyc(0, I_LD, 0, 0, 4'hF, E(ST_MEM_ACC, 1,0,1,0, 0,0,0, REG_TEMP0,DC,C_NOLOAD, ALU_NOP, 4'b0100), "ld_wait");
        cyc(0, I_LD, 1, 0, 4'hF, E(ST_MEM_ACC, 1,0,1,0, 0,0,1, REG_TEMP0,DC,DC, ALU_NOP, 4'b0100), "ld_ack_load_rd");
        cyc(0, I_LD, 0, 0, 4'hF, E(ST_PC_INC, 0,0,0,0, 0,0,0, REG_PC,DC,C_PC, ALU_INC4, 4'b0100), "ld_pcinc_memrd_low");
        // be +4 with z=1: taken
        cyc(0, I_BE4, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'b0100), "be_fetch");
        cyc(0, I_BE4, 0, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0100), "be_decode");
        cyc(0, I_BE4, 0, 0, 4'hF, E(ST_BRANCH, 0,0,0,0, 0,0,0, REG_PC,REG_IR,C_PC, ALU_BRDISP, 4'b0100), "be_taken");
        // orcc with rd=0: no register write, carry only
        cyc(0, I_ORCC0, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'b0100), "orcc_fetch_after_taken");
        cyc(0, I_ORCC0, 0, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0100), "orcc_decode");
        cyc(0, I_ORCC0, 0, 1, 4'b1110, E(ST_EXEC, 0,0,0,0, 1,1,0, DC,DC,C_NOLOAD, ALU_ORCC, 4'b0100), "orcc_rd0_noload");
        cyc(0, I_ORCC0, 0, 0, 4'hF, E(ST_PC_INC, 0,0,0,0, 0,0,0, REG_PC,DC,C_PC, ALU_INC4, 4'b0001), "orcc_psr_update");
        // be with z=0: not taken
        cyc(0, I_BE4, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'b0001), "be2_fetch");
        cyc(0, I_BE4, 0, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0001), "be2_decode");
        cyc(0, I_BE4, 0, 0, 4'hF, E(ST_BRANCH, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0001), "be_not_taken");
        cyc(0, I_BE4, 0, 0, 4'hF, E(ST_PC_INC, 0,0,0,0, 0,0,0, REG_PC,DC,C_PC, ALU_INC4, 4'b0001), "be_nt_pcinc");
        // illegal instruction halts until reset
        cyc(0, I_ILL, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'b0001), "ill_fetch");
        cyc(0, I_ILL, 0, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0001), "ill_decode");
        for (int h = 0; h < 20; h++)
            cyc(0, I_ILL, h[0], 1, 4'h0, E(ST_HALT, 0,0,0,1, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'b0001), "halt_hold");
        cyc(1, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "halt_reset");
        cyc(0, 0, 0, 0, 4'hF, E(ST_RESET, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "halt_release");
        // st r3,[r1+r2], zero-wait
        cyc(0, I_ST, 1, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_IR, ALU_NOP, 4'h0), "st_fetch");
        cyc(0, I_ST, 0, 0, 4'hF, E(ST_DECODE, 0,0,0,0, 0,0,0, DC,DC,C_NOLOAD, ALU_NOP, 4'h0), "st_decode");
        cyc(0, I_ST, 0, 0, 4'hF, E(ST_MEM_ADDR, 0,0,0,0, 1,1,0, DC,DC,C_TEMP0, ALU_ADD, 4'h0), "st_mem_addr");
        cyc(0, I_ST, 1, 0, 4'hF, E(ST_MEM_ACC, 0,1,0,0, 0,0,0, REG_TEMP0,6'd3,C_NOLOAD, ALU_NOP, 4'h0), "st_ack");
        cyc(0, I_ST, 0, 0, 4'hF, E(ST_PC_INC, 0,0,0,0, 0,0,0, REG_PC,DC,C_PC, ALU_INC4, 4'h0), "st_pcinc_memwr_low");
        cyc(0, 0, 0, 0, 4'hF, E(ST_FETCH, 1,0,1,0, 0,0,0, REG_PC,DC,C_NOLOAD, ALU_NOP, 4'h0), "st_back_to_fetch");

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
